// File: rtl/btn_debounce_pkg.sv
// Shared constants and state encoding for the push-button conditioning logic
// that feeds the pipeline's single-step enable.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_e;

  // 10 ms of stability at the 100 MHz board clock.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;
  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

endpackage : btn_debounce_pkg

// File: rtl/btn_debounce_pulse_sync_ff.sv
// Generic multi-stage single-bit synchroniser for asynchronous board inputs.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule : sync_ff

// File: rtl/btn_debounce_pulse.sv
// Debounces a raw push-button and emits one-cycle press/release pulses plus a
// clean level; all outputs come straight from flops.
module btn_debounce_pulse
  import btn_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic            w_btn_s;
  db_state_e       r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic            w_cnt_done;
  logic            w_press_next, w_release_next, w_level_next;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_btn),
    .o_q  (w_btn_s)
  );

  assign w_cnt_done = (r_cnt == CNT_MAX);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next_state   = r_state;
    w_cnt_next     = r_cnt;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    unique case (r_state)
      S_LOW: begin
        if (w_btn_s) begin
          w_next_state = S_RISE;
          w_cnt_next   = '0;
        end
      end
      S_RISE: begin
        if (!w_btn_s) begin
          w_next_state = S_LOW;
          w_cnt_next   = '0;
        end else if (w_cnt_done) begin
          w_next_state = S_HIGH;
          w_cnt_next   = '0;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!w_btn_s) begin
          w_next_state = S_FALL;
          w_cnt_next   = '0;
        end
      end
      S_FALL: begin
        if (w_btn_s) begin
          w_next_state = S_HIGH;
          w_cnt_next   = '0;
        end else if (w_cnt_done) begin
          w_next_state   = S_LOW;
          w_cnt_next     = '0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = S_LOW;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Level tracks the accepted state so it flips on the same edge as the pulse.
  assign w_level_next = (w_next_state == S_HIGH) || (w_next_state == S_FALL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_LOW;
      r_cnt           <= '0;
      o_btn_level     <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_cnt           <= w_cnt_next;
      o_btn_level     <= w_level_next;
      o_press_pulse   <= w_press_next;
      o_release_pulse <= w_release_next;
    end
  end

endmodule : btn_debounce_pulse

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with STABLE_CYCLES=8, SYNC_STAGES=2:
// accepted edges surface 10 clock edges after the input change.
module tb_btn_debounce_pulse;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic level, press, release_p;

  int checks = 0;
  int errors = 0;

  int press_cnt, release_cnt, level_falls, level_hi_seen, viol;
  logic prev_press, prev_release, prev_level;

  btn_debounce_pulse #(
    .STABLE_CYCLES(8),
    .SYNC_STAGES  (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_btn          (btn),
    .o_btn_level    (level),
    .o_press_pulse  (press),
    .o_release_pulse(release_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    press_cnt     = 0;
    release_cnt   = 0;
    level_falls   = 0;
    level_hi_seen = 0;
    viol          = 0;
  endtask

  // Advance n edges, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (press) press_cnt++;
      if (release_p) release_cnt++;
      if (level) level_hi_seen++;
      if (prev_level && !level) level_falls++;
      if (press && release_p) viol++;
      if (press && prev_press) viol++;
      if (release_p && prev_release) viol++;
      prev_press   = press;
      prev_release = release_p;
      prev_level   = level;
    end
  endtask

  initial begin
    prev_press = 1'b0; prev_release = 1'b0; prev_level = 1'b0;
    clear_stats();
    rst = 1'b1;
    btn = 1'b0;
    tick(3);
    check("reset_level",   int'(level),     0);
    check("reset_press",   int'(press),     0);
    check("reset_release", int'(release_p), 0);
    rst = 1'b0;
    tick(2);

    // Clean press: pulse only after edge 10.
    clear_stats();
    btn = 1'b1;
    tick(10);
    check("clean_press_e9",  int'(press), 0);
    check("clean_level_e9",  int'(level), 0);
    tick(1);
    check("clean_press_e10", int'(press), 1);
    check("clean_level_e10", int'(level), 1);
    tick(1);
    check("clean_press_e11", int'(press), 0);
    tick(18);
    check("clean_press_cnt",   press_cnt,   1);
    check("clean_release_cnt", release_cnt, 0);

    // Release after the clean press.
    clear_stats();
    btn = 1'b0;
    tick(10);
    check("release_pulse_e9",  int'(release_p), 0);
    check("release_level_e9",  int'(level),     1);
    tick(1);
    check("release_pulse_e10", int'(release_p), 1);
    check("release_level_e10", int'(level),     0);
    tick(1);
    check("release_pulse_e11", int'(release_p), 0);
    tick(10);
    check("release_cnt",       release_cnt, 1);
    check("release_press_cnt", press_cnt,   0);

    // Bouncy press: 3 high / 2 low four times, then steady high.
    clear_stats();
    for (int b = 0; b < 4; b++) begin
      btn = 1'b1; tick(3);
      btn = 1'b0; tick(2);
    end
    btn = 1'b1;
    tick(10);
    check("bounce_no_early_press", press_cnt,   0);
    check("bounce_level_e9",       int'(level), 0);
    tick(1);
    check("bounce_press_e10",      int'(press), 1);
    tick(10);
    check("bounce_press_cnt",      press_cnt,   1);
    btn = 1'b0;
    tick(22);
    check("bounce_release_cnt",    release_cnt, 1);

    // Glitch: 5-cycle high excursion must be ignored.
    clear_stats();
    btn = 1'b1; tick(5);
    btn = 1'b0; tick(20);
    check("glitch_press_cnt",   press_cnt,     0);
    check("glitch_release_cnt", release_cnt,   0);
    check("glitch_level_seen",  level_hi_seen, 0);

    // Reset while the rise counter holds 5 (after edge 7), button kept high.
    clear_stats();
    btn = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(1);
    check("midrst_level",   int'(level),     0);
    check("midrst_press",   int'(press),     0);
    check("midrst_release", int'(release_p), 0);
    rst = 1'b0;
    clear_stats();
    tick(10);
    check("midrst_press_e9",  int'(press), 0);
    check("midrst_level_e9",  int'(level), 0);
    tick(1);
    check("midrst_press_e10", int'(press), 1);
    check("midrst_level_e10", int'(level), 1);
    tick(10);
    check("midrst_press_cnt", press_cnt, 1);
    btn = 1'b0;
    tick(25);
    check("midrst_release_cnt", release_cnt, 1);

    // Long hold: one press, no auto-repeat, level stays high.
    clear_stats();
    btn = 1'b1;
    tick(1000);
    check("hold_press_cnt",   press_cnt,   1);
    check("hold_release_cnt", release_cnt, 0);
    check("hold_level_falls", level_falls, 0);
    check("hold_level_end",   int'(level), 1);
    check("hold_pulse_rules", viol,        0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_btn_debounce_pulse

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Conditions a raw mechanical push-button into a clean, single-clock-cycle press pulse for the pipeline's single-step clock-enable input. The pipeline toggles its clock enable on every cycle that input is high, so it must see exactly one high cycle per physical press. This block sits directly upstream of the pipeline top. It synchronises the asynchronous button, rejects bounce with a stability counter, and emits press and release pulses plus a debounced level.

## Interface
Parameters:
- STABLE_CYCLES, default 1_000_000 (10 ms at 100 MHz): consecutive synchronised cycles an input change must persist before it is accepted. Legal range is 2 or more.
- SYNC_STAGES, default 2: flip-flop depth of the input synchroniser. Legal range is 2 or more.

Ports:
- i_clk, input, 1 bit: the single clock.
- i_rst, input, 1 bit: reset, synchronous, active-high.
- i_btn, input, 1 bit: raw button level, asynchronous to i_clk, active-high.
- o_btn_level, output, 1 bit: debounced button level.
- o_press_pulse, output, 1 bit: high for one cycle per accepted press. It drives the pipeline's step/enable input.
- o_release_pulse, output, 1 bit: high for one cycle per accepted release.

## Operation
- **Synchroniser:** SYNC_STAGES-deep shift register on i_btn; its last stage is `btn_s`.
- **Counter:** width $clog2(STABLE_CYCLES). It clears on every state transition and on every bounce return, and saturates at STABLE_CYCLES-1.
- **FSM (4 states):**
  - S_LOW: o_btn_level=0. If btn_s=1, go to S_RISE and clear the counter.
  - S_RISE: o_btn_level=0. If btn_s=0, go to S_LOW (bounce rejected, no pulse). Otherwise increment the counter. When the counter equals STABLE_CYCLES-1 and btn_s=1, go to S_HIGH and assert o_press_pulse on the registered output for one cycle.
  - S_HIGH: o_btn_level=1. If btn_s=0, go to S_FALL and clear the counter.
  - S_FALL: o_btn_level=1. If btn_s=1, go to S_HIGH (no pulse). Otherwise count. When the count completes, go to S_LOW and assert o_release_pulse for one cycle.
- **Registered outputs:** all outputs are registered; there are no combinational paths from i_btn.
- **Pulse exclusivity:** o_press_pulse and o_release_pulse are never high in the same cycle. Each is never high for two consecutive cycles.
- **Long holds:** a held button produces exactly one press pulse, regardless of hold length. There is no auto-repeat.
- **Reset:** state S_LOW, counter 0, synchroniser flops 0, all outputs 0.
  - Reset applied mid-S_RISE or mid-S_FALL aborts the pending pulse.
  - If the button is held through reset release, it is treated as a new press: a press pulse follows after the full latency.

## Timing
- Edge 0 is the first i_clk edge at which i_btn is sampled high and stays high.
- o_press_pulse and o_btn_level=1 become visible after edge SYNC_STAGES+STABLE_CYCLES. Release is symmetric for o_release_pulse and o_btn_level=0.
- A high or low excursion of btn_s shorter than STABLE_CYCLES cycles produces no pulse and no level change.
- The counter restarts from 0 on each bounce return, so latency is measured from the last transition of i_btn.
- o_press_pulse is exactly one i_clk cycle wide. This makes it safe for the pipeline's toggle-on-high enable logic.
- After reset deassertion, with i_btn held high, the first pulse appears after edge SYNC_STAGES+STABLE_CYCLES, counted from the first edge with i_rst=0.

## Structure
- **Shared package (pipeline support constants):**
  - 2-bit state encoding: S_LOW=0, S_RISE=1, S_HIGH=2, S_FALL=3.
  - Default STABLE_CYCLES for board clock frequency.
- **Sub-module sync_ff:** a generic SYNC_STAGES-deep single-bit synchroniser with synchronous active-high reset. It is reused for other asynchronous board inputs.
- **Main module:** holds the FSM, the counter and the output registers.

## Test plan
Run with STABLE_CYCLES=8, SYNC_STAGES=2; edge numbers are relative to i_btn rising at edge 0.
1. **Clean press:** i_btn=1 for 30 cycles. o_press_pulse is high only in the cycle after edge 10. o_btn_level goes 1 at the same edge. No other pulse occurs.
2. **Bouncy press:** i_btn alternates high 3 cycles / low 2 cycles, four times, then stays high. There is exactly one press pulse, 10 edges after the final rise.
3. **Glitch:** i_btn=1 for 5 cycles, then 0. o_press_pulse and o_release_pulse stay 0 throughout, and o_btn_level stays 0.
4. **Release:** after scenario 1, set i_btn=0 and hold it. o_release_pulse is high for one cycle, 10 edges after the fall. o_btn_level drops to 0 in that cycle.
5. **Reset mid-count:** assert i_rst for 1 cycle when the S_RISE counter is 5, with i_btn still high.
   - All outputs read 0 in the next cycle.
   - One press pulse follows, 10 edges after the first edge with i_rst=0.
6. **Long hold:** i_btn=1 for 1000 cycles. Exactly one o_press_pulse occurs, and o_btn_level stays 1 throughout after acceptance.
